// File: rtl/soc_bus_pkg.sv
// Shared SoC bus constants: master indices and the all-zero write-enable read code.
package soc_bus_pkg;
   localparam logic       M_INST   = 1'b0;
   localparam logic       M_DATA   = 1'b1;
   localparam logic [3:0] WEN_READ = 4'b0000;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grant is combinational (0 cycles), last winner registered.
// Backpressure: a losing requester simply sees no grant and keeps its request up.
module rr_arb2
   import soc_bus_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       gnt_id
);

   logic last;

   // Under contention the master that did not win most recently is served.
   always_comb begin
      grant = 2'b00;
      if (resetn) begin
         if (req == 2'b11) begin
            grant = (last == M_DATA) ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

   assign gnt_id = grant[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last <= M_DATA;
      end else if (|grant) begin
         last <= gnt_id;
      end
   end

endmodule

// File: rtl/sram_arb_2x1.sv
// Shares one 1-cycle-latency single-port SRAM between two masters; accept 0 cycles, read data +1 cycle.
// Backpressure: ungranted master sees ready=0 and holds its request; returned data held until its next read.
module sram_arb_2x1
   import soc_bus_pkg::*;
#(
   parameter int RAM_AW = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_en,
   input  logic [3:0]        m0_wen,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   input  logic              m1_en,
   input  logic [3:0]        m1_wen,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   logic [1:0]  grant;
   logic        gnt_id;
   logic [3:0]  sel_wen;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        pend_vld;
   logic        pend_id;
   logic [31:0] hold_0;
   logic [31:0] hold_1;
   logic        unused_addr_bits;

   rr_arb2 u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    ({m1_en, m0_en}),
      .grant  (grant),
      .gnt_id (gnt_id)
   );

   assign sel_wen   = (gnt_id == M_DATA) ? m1_wen   : m0_wen;
   assign sel_addr  = (gnt_id == M_DATA) ? m1_addr  : m0_addr;
   assign sel_wdata = (gnt_id == M_DATA) ? m1_wdata : m0_wdata;

   assign m0_ready  = grant[0];
   assign m1_ready  = grant[1];

   assign ram_en    = |grant;
   assign ram_wen   = ram_en ? sel_wen : WEN_READ;
   assign ram_addr  = sel_addr[RAM_AW+1:2];
   assign ram_wdata = sel_wdata;

   // Byte offset and region bits are decoded upstream.
   assign unused_addr_bits = ^{sel_addr[31:RAM_AW+2], sel_addr[1:0]};

   assign m0_rvalid = pend_vld && (pend_id == M_INST);
   assign m1_rvalid = pend_vld && (pend_id == M_DATA);
   assign m0_rdata  = m0_rvalid ? ram_rdata : hold_0;
   assign m1_rdata  = m1_rvalid ? ram_rdata : hold_1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_vld <= 1'b0;
         pend_id  <= M_INST;
         hold_0   <= '0;
         hold_1   <= '0;
      end else begin
         pend_vld <= ram_en && (sel_wen == WEN_READ);
         pend_id  <= gnt_id;
         if (m0_rvalid) hold_0 <= ram_rdata;
         if (m1_rvalid) hold_1 <= ram_rdata;
      end
   end

endmodule
